cov_accum: RTL and testbench

Covariance front-end of the OBB pipeline, directly upstream of the iteration controller. Accepts a stream of N_PTS signed 3-D points, accumulates first- and second-order sums, then computes the six unique entries of the 3x3 covariance matrix. When the matrix is ready it emits a one-cycle `ctrl_cov` pulse that starts the controller's Jacobi sweep, and holds the results stable for the downstream rotate stage.

---
 rtl/obb_pkg.sv | 23 ++
 rtl/cov_entry_calc.sv | 29 ++
 rtl/cov_accum.sv | 172 +++++++++++++++++
 tb/tb_cov_accum.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/obb_pkg.sv
// Definitions shared across the OBB pipeline: default data widths,
// the covariance front-end state encoding and covariance entry indices.
package obb_pkg;

    localparam int OBB_DW    = 16;
    localparam int OBB_LOG2N = 3;

    typedef enum logic [1:0] {
        CA_IDLE = 2'd0,
        CA_ACC  = 2'd1,
        CA_CALC = 2'd2,
        CA_DONE = 2'd3
    } cov_state_e;

    // Order in which CALC produces the covariance entries.
    localparam logic [2:0] COV_XX = 3'd0;
    localparam logic [2:0] COV_XY = 3'd1;
    localparam logic [2:0] COV_XZ = 3'd2;
    localparam logic [2:0] COV_YY = 3'd3;
    localparam logic [2:0] COV_YZ = 3'd4;
    localparam logic [2:0] COV_ZZ = 3'd5;

endpackage

// File: rtl/cov_entry_calc.sv
// One covariance entry from its sums: (N*S_ab - S_a*S_b) >>> 2*LOG2N.
// The single instance in cov_accum holds the multiplier shared by all six entries.
module cov_entry_calc #(
    parameter int DW    = 16,
    parameter int LOG2N = 3,
    parameter int CW    = 2*DW
) (
    input  logic [2*DW+LOG2N-1:0] s_ab_i,
    input  logic [DW+LOG2N-1:0]   s_a_i,
    input  logic [DW+LOG2N-1:0]   s_b_i,
    output logic [CW-1:0]         c_ab_o
);

    localparam int FW = 2*DW + 2*LOG2N + 1;

    logic signed [FW-1:0] ab_w;
    logic signed [FW-1:0] a_w;
    logic signed [FW-1:0] b_w;
    logic signed [FW-1:0] diff;

    assign ab_w = {{(LOG2N+1){s_ab_i[2*DW+LOG2N-1]}}, s_ab_i};
    assign a_w  = {{(DW+LOG2N+1){s_a_i[DW+LOG2N-1]}}, s_a_i};
    assign b_w  = {{(DW+LOG2N+1){s_b_i[DW+LOG2N-1]}}, s_b_i};

    // Result magnitude is bounded by 2^(2DW-2), so plain truncation is exact.
    assign diff   = (ab_w <<< LOG2N) - (a_w * b_w);
    assign c_ab_o = CW'(diff >>> (2*LOG2N));

endmodule

// File: rtl/cov_accum.sv
// Covariance front-end: accumulates N_PTS points, then computes the six
// covariance entries one per cycle and pulses ctrl_cov to the controller.
module cov_accum
    import obb_pkg::*;
#(
    parameter int DW    = OBB_DW,
    parameter int LOG2N = OBB_LOG2N,
    parameter int CW    = 2*DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          pt_valid,
    input  logic [DW-1:0] pt_x,
    input  logic [DW-1:0] pt_y,
    input  logic [DW-1:0] pt_z,
    output logic          pt_ready,
    output logic          busy,
    output logic          ctrl_cov,
    output logic [CW-1:0] cov_xx,
    output logic [CW-1:0] cov_xy,
    output logic [CW-1:0] cov_xz,
    output logic [CW-1:0] cov_yy,
    output logic [CW-1:0] cov_yz,
    output logic [CW-1:0] cov_zz,
    output logic [1:0]    dbg_state_o
);

    localparam int             SW   = DW + LOG2N;
    localparam int             QW   = 2*DW + LOG2N;
    localparam logic [LOG2N:0] LAST = (LOG2N+1)'((1 << LOG2N) - 1);

    // Handshake: a point transfers on any rising edge where pt_valid && pt_ready.
    cov_state_e state_q, state_d;
    logic [LOG2N:0] cnt_q, cnt_d;
    logic [2:0]     k_q, k_d;
    logic signed [SW-1:0] sx_q, sy_q, sz_q, sx_d, sy_d, sz_d;
    logic signed [QW-1:0] sxx_q, sxy_q, sxz_q, syy_q, syz_q, szz_q;
    logic signed [QW-1:0] sxx_d, sxy_d, sxz_d, syy_d, syz_d, szz_d;
    logic [CW-1:0] cov_xx_q, cov_xy_q, cov_xz_q, cov_yy_q, cov_yz_q, cov_zz_q;

    logic signed [2*DW-1:0] xw, yw, zw;
    logic signed [2*DW-1:0] pxx, pxy, pxz, pyy, pyz, pzz;
    logic accept, clear;
    logic [QW-1:0] s_ab;
    logic [SW-1:0] s_a, s_b;
    logic [CW-1:0] c_ab;

    assign accept = pt_valid && (state_q == CA_ACC);
    assign clear  = start && ((state_q == CA_IDLE) || (state_q == CA_DONE));

    assign xw  = {{DW{pt_x[DW-1]}}, pt_x};
    assign yw  = {{DW{pt_y[DW-1]}}, pt_y};
    assign zw  = {{DW{pt_z[DW-1]}}, pt_z};
    assign pxx = xw * xw;
    assign pxy = xw * yw;
    assign pxz = xw * zw;
    assign pyy = yw * yw;
    assign pyz = yw * zw;
    assign pzz = zw * zw;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        sx_d = sx_q;   sy_d = sy_q;   sz_d = sz_q;
        sxx_d = sxx_q; sxy_d = sxy_q; sxz_d = sxz_q;
        syy_d = syy_q; syz_d = syz_q; szz_d = szz_q;
        case (state_q)
            CA_IDLE: if (start) state_d = CA_ACC;
            CA_ACC: begin
                if (accept) begin
                    cnt_d = cnt_q + 1'b1;
                    sx_d  = sx_q + {{LOG2N{pt_x[DW-1]}}, pt_x};
                    sy_d  = sy_q + {{LOG2N{pt_y[DW-1]}}, pt_y};
                    sz_d  = sz_q + {{LOG2N{pt_z[DW-1]}}, pt_z};
                    sxx_d = sxx_q + {{LOG2N{pxx[2*DW-1]}}, pxx};
                    sxy_d = sxy_q + {{LOG2N{pxy[2*DW-1]}}, pxy};
                    sxz_d = sxz_q + {{LOG2N{pxz[2*DW-1]}}, pxz};
                    syy_d = syy_q + {{LOG2N{pyy[2*DW-1]}}, pyy};
                    syz_d = syz_q + {{LOG2N{pyz[2*DW-1]}}, pyz};
                    szz_d = szz_q + {{LOG2N{pzz[2*DW-1]}}, pzz};
                    if (cnt_q == LAST) begin
                        state_d = CA_CALC;
                        k_d     = COV_XX;
                    end
                end
            end
            CA_CALC: begin
                k_d = k_q + 1'b1;
                if (k_q == COV_ZZ) state_d = CA_DONE;
            end
            CA_DONE: state_d = start ? CA_ACC : CA_IDLE;
            default: state_d = CA_IDLE;
        endcase
        if (clear) begin
            cnt_d = '0;
            sx_d = '0;  sy_d = '0;  sz_d = '0;
            sxx_d = '0; sxy_d = '0; sxz_d = '0;
            syy_d = '0; syz_d = '0; szz_d = '0;
        end
    end

    always_comb begin
        s_ab = sxx_q;
        s_a  = sx_q;
        s_b  = sx_q;
        case (k_q)
            COV_XY:  begin s_ab = sxy_q; s_b = sy_q; end
            COV_XZ:  begin s_ab = sxz_q; s_b = sz_q; end
            COV_YY:  begin s_ab = syy_q; s_a = sy_q; s_b = sy_q; end
            COV_YZ:  begin s_ab = syz_q; s_a = sy_q; s_b = sz_q; end
            COV_ZZ:  begin s_ab = szz_q; s_a = sz_q; s_b = sz_q; end
            default: ;
        endcase
    end

    cov_entry_calc #(.DW(DW), .LOG2N(LOG2N), .CW(CW)) u_entry (
        .s_ab_i (s_ab),
        .s_a_i  (s_a),
        .s_b_i  (s_b),
        .c_ab_o (c_ab)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= CA_IDLE;
            cnt_q   <= '0;
            k_q     <= '0;
            sx_q <= '0;  sy_q <= '0;  sz_q <= '0;
            sxx_q <= '0; sxy_q <= '0; sxz_q <= '0;
            syy_q <= '0; syz_q <= '0; szz_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            sx_q <= sx_d;   sy_q <= sy_d;   sz_q <= sz_d;
            sxx_q <= sxx_d; sxy_q <= sxy_d; sxz_q <= sxz_d;
            syy_q <= syy_d; syz_q <= syz_d; szz_q <= szz_d;
        end
    end

    // Results hold until overwritten by the next CALC, even across a restart.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cov_xx_q <= '0; cov_xy_q <= '0; cov_xz_q <= '0;
            cov_yy_q <= '0; cov_yz_q <= '0; cov_zz_q <= '0;
        end else if (state_q == CA_CALC) begin
            case (k_q)
                COV_XX:  cov_xx_q <= c_ab;
                COV_XY:  cov_xy_q <= c_ab;
                COV_XZ:  cov_xz_q <= c_ab;
                COV_YY:  cov_yy_q <= c_ab;
                COV_YZ:  cov_yz_q <= c_ab;
                COV_ZZ:  cov_zz_q <= c_ab;
                default: ;
            endcase
        end
    end

    assign pt_ready    = (state_q == CA_ACC);
    assign busy        = (state_q == CA_ACC) || (state_q == CA_CALC);
    assign ctrl_cov    = (state_q == CA_DONE);
    assign dbg_state_o = state_q;
    assign cov_xx = cov_xx_q;
    assign cov_xy = cov_xy_q;
    assign cov_xz = cov_xz_q;
    assign cov_yy = cov_yy_q;
    assign cov_yz = cov_yz_q;
    assign cov_zz = cov_zz_q;

endmodule

// File: tb/tb_cov_accum.sv
// Directed bench for cov_accum: hand-computed covariance results, frame timing,
// backpressure, ignored/accepted start pulses and mid-frame reset.
module tb_cov_accum;
    import obb_pkg::*;

    localparam int DW = 16;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          pt_valid = 1'b0;
    logic [DW-1:0] pt_x = '0;
    logic [DW-1:0] pt_y = '0;
    logic [DW-1:0] pt_z = '0;
    logic          pt_ready, busy, ctrl_cov;
    logic [CW-1:0] cov_xx, cov_xy, cov_xz, cov_yy, cov_yz, cov_zz;
    logic [1:0]    dbg_state;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int start_cyc = 0;
    int acc_cyc = 0;
    int ctrl_cyc = 0;
    logic [CW-1:0] exp_q[$];
    logic [DW-1:0] px[8];
    logic [DW-1:0] py[8];
    logic [DW-1:0] pz[8];

    cov_accum dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .pt_valid    (pt_valid),
        .pt_x        (pt_x),
        .pt_y        (pt_y),
        .pt_z        (pt_z),
        .pt_ready    (pt_ready),
        .busy        (busy),
        .ctrl_cov    (ctrl_cov),
        .cov_xx      (cov_xx),
        .cov_xy      (cov_xy),
        .cov_xz      (cov_xz),
        .cov_yy      (cov_yy),
        .cov_yz      (cov_yz),
        .cov_zz      (cov_zz),
        .dbg_state_o (dbg_state)
    );

    // Clock / reset infrastructure; all bench activity happens on the falling edge.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [CW-1:0] xx, input logic [CW-1:0] xy, input logic [CW-1:0] xz,
                            input logic [CW-1:0] yy, input logic [CW-1:0] yz, input logic [CW-1:0] zz);
        exp_q.push_back(xx); exp_q.push_back(xy); exp_q.push_back(xz);
        exp_q.push_back(yy); exp_q.push_back(yz); exp_q.push_back(zz);
    endtask

    task automatic check_cov(input string tag);
        logic [CW-1:0] e;
        e = exp_q.pop_front(); check({tag, "_xx"}, cov_xx, e);
        e = exp_q.pop_front(); check({tag, "_xy"}, cov_xy, e);
        e = exp_q.pop_front(); check({tag, "_xz"}, cov_xz, e);
        e = exp_q.pop_front(); check({tag, "_yy"}, cov_yy, e);
        e = exp_q.pop_front(); check({tag, "_yz"}, cov_yz, e);
        e = exp_q.pop_front(); check({tag, "_zz"}, cov_zz, e);
    endtask

    task automatic load_pattern(input int p);
        for (int i = 0; i < 8; i++) begin
            case (p)
                0: begin px[i] = 16'd1; py[i] = 16'd2; pz[i] = 16'd3; end
                1: begin px[i] = (i % 2 == 0) ? 16'd1 : 16'hFFFF; py[i] = 16'd0; pz[i] = 16'd0; end
                2: begin
                    px[i] = (i % 2 == 0) ? 16'd2 : 16'hFFFE;
                    py[i] = px[i];
                    pz[i] = 16'd5;
                end
                3: begin
                    px[i] = (i == 0) ? 16'd100 : 16'd0;
                    py[i] = (i == 1) ? 16'd100 : 16'd0;
                    pz[i] = 16'd0;
                end
                default: begin px[i] = (i % 2 == 0) ? 16'h7FFF : 16'h8000; py[i] = 16'd0; pz[i] = 16'd0; end
            endcase
        end
    endtask

    // Driver tasks: entered and left just after a falling edge.
    task automatic pulse_start();
        start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic feed(input int n, input bit gaps, input bit start_in_acc, input bit ninth);
        int i = 0;
        int budget = 300;
        logic rdy;
        while (i < n && budget > 0) begin
            pt_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            pt_x = px[i]; pt_y = py[i]; pt_z = pz[i];
            start = start_in_acc && (i == 3);
            rdy = pt_ready;
            if (pt_valid && rdy) acc_cyc = cyc;
            @(negedge clk);
            budget--;
            if (pt_valid && rdy) i++;
        end
        start = 1'b0;
        pt_valid = 1'b0;
        check("feed_count", i, n);
        if (ninth) begin
            check("ready_drop", pt_ready, 1'b0);
            pt_valid = 1'b1;
            pt_x = 16'h1234; pt_y = 16'h0FF0; pt_z = 16'h7000;
            repeat (2) @(negedge clk);
            pt_valid = 1'b0;
        end
    endtask

    task automatic wait_done(input bit start_in_calc, input bit start_in_done);
        int budget = 40;
        bit pulsed = 1'b0;
        while (!ctrl_cov && budget > 0) begin
            start = start_in_calc && !pulsed && (dbg_state == CA_CALC);
            if (start) pulsed = 1'b1;
            @(negedge clk);
            budget--;
        end
        check("ctrl_seen", ctrl_cov, 1'b1);
        ctrl_cyc = cyc;
        start = start_in_done;
    endtask

    task automatic frame(input int p, input bit gaps, input bit s_acc, input bit s_calc,
                         input bit ninth, input string tag);
        load_pattern(p);
        pulse_start();
        feed(8, gaps, s_acc, ninth);
        wait_done(s_calc, 1'b0);
        check_cov(tag);
        @(negedge clk);
        check({tag, "_pulse_end"}, ctrl_cov, 1'b0);
    endtask

    initial begin
        int pulses;
        repeat (3) @(negedge clk);
        check("rst_ready", pt_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ctrl", ctrl_cov, 1'b0);
        check("rst_state", dbg_state, CA_IDLE);
        check("rst_cov_xx", cov_xx, 0);
        check("rst_cov_zz", cov_zz, 0);
        rst = 1'b1;
        @(negedge clk);

        // Constant points: zero covariance, minimum frame timing.
        load_pattern(0);
        push_exp(0, 0, 0, 0, 0, 0);
        pulse_start();
        check("ready_after_start", pt_ready, 1'b1);
        check("busy_acc", busy, 1'b1);
        feed(8, 1'b0, 1'b0, 1'b0);
        check("busy_calc", busy, 1'b1);
        check("state_calc", dbg_state, CA_CALC);
        wait_done(1'b0, 1'b0);
        check("frame_len", ctrl_cyc - start_cyc + 1, 16);
        check("acc_to_ctrl", ctrl_cyc - acc_cyc, 7);
        check_cov("const");
        @(negedge clk);
        check("ctrl_one_cycle", ctrl_cov, 1'b0);
        check("idle_after_done", dbg_state, CA_IDLE);

        push_exp(1, 0, 0, 0, 0, 0);
        frame(1, 1'b0, 1'b0, 1'b0, 1'b0, "alt1");
        push_exp(4, 4, 0, 4, 0, 0);
        frame(2, 1'b0, 1'b0, 1'b0, 1'b0, "pm2");
        push_exp(4, 4, 0, 4, 0, 0);
        frame(2, 1'b1, 1'b0, 1'b0, 1'b1, "gaps");

        // Start in ACC and CALC ignored; start in DONE restarts.
        load_pattern(2);
        push_exp(4, 4, 0, 4, 0, 0);
        pulse_start();
        feed(8, 1'b0, 1'b1, 1'b0);
        wait_done(1'b1, 1'b1);
        check_cov("restart");
        @(negedge clk);
        start = 1'b0;
        check("restart_pulse_end", ctrl_cov, 1'b0);
        check("restart_ready", pt_ready, 1'b1);
        check("restart_hold_xx", cov_xx, 4);
        load_pattern(3);
        push_exp(1093, 32'hFFFFFF63, 0, 1093, 0, 0);
        feed(8, 1'b0, 1'b0, 1'b0);
        wait_done(1'b0, 1'b0);
        check_cov("floor");
        @(negedge clk);

        push_exp(32'h3FFF8000, 0, 0, 0, 0, 0);
        frame(4, 1'b0, 1'b0, 1'b0, 1'b0, "extreme");

        // Reset mid-ACC after four accepts.
        load_pattern(2);
        pulse_start();
        feed(4, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("abort_ready", pt_ready, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_ctrl", ctrl_cov, 1'b0);
        check("abort_state", dbg_state, CA_IDLE);
        check("abort_cov_xx", cov_xx, 0);
        rst = 1'b1;
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (ctrl_cov) pulses++;
        end
        check("abort_no_pulse", pulses, 0);
        push_exp(1, 0, 0, 0, 0, 0);
        frame(1, 1'b0, 1'b0, 1'b0, 1'b0, "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
